audio_fifo_responder: RTL and testbench
=======================================

Name: audio_fifo_responder

Overview:
- Avalon-MM slave implementing the four-register audio core window: control, fifospace, left data and right data.
- Bus masters write DAC samples into it and read ADC samples out of it.
- Internally it holds four FIFOs: DAC left/right, filled by the bus and drained by the codec serializer; ADC left/right, filled by the deserializer and drained by the bus.
- Sits between the bus fabric and the codec serializer/deserializer.

Parameters:
- BASE_ADDR, 32'h00003040, byte address of the control register; the window is 16 bytes.
- DEPTH, 128, entries per FIFO; a power of 2, no larger than 128.
- DW, 32, sample width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- bus_addr  in  32  byte address from the master
- bus_read  in  1  read request, held until ack is seen
- bus_write  in  1  write request, held until ack is seen
- bus_byte_enable  in  4  byte mask; honoured only for control writes
- bus_write_data  in  32  write data
- bus_read_data  out  32  read data, valid while bus_ack=1
- bus_ack  out  1  one-cycle transaction-complete pulse
- dac_req  in  1  one-cycle pulse per output sample period
- dac_left  out  DW  left sample to codec
- dac_right  out  DW  right sample to codec
- dac_valid  out  1  pulse one cycle after dac_req
- adc_val  in  1  one-cycle pulse: new stereo input sample
- adc_left  in  DW  left input sample
- adc_right  in  DW  right input sample

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE; all FIFOs emptied; overrun/underrun flags cleared. bus_ack=0, bus_read_data=0, dac_left=0, dac_right=0, dac_valid=0.
- Address decode: hit when bus_addr[31:4]==BASE_ADDR[31:4]. Offset = bus_addr[3:2]: 0 control, 1 fifospace, 2 left data, 3 right data. Misses are ignored with no ack; another responder owns them.
- FSM states: IDLE, ACK, RELEASE.
  - IDLE: on a hit with bus_read or bus_write, perform the access, register bus_read_data, assert bus_ack, go to ACK. If bus_read and bus_write are both high, the read wins.
  - ACK: deassert bus_ack, go to RELEASE.
  - RELEASE: return to IDLE once bus_read=0 and bus_write=0. This prevents double pops or pushes while the master is dropping its request.
  - Latency: ack is asserted on the cycle after the request is first sampled.
- Control register (offset 0):
  - Write: bit0=1 with be[0] clears both ADC FIFOs; bit1=1 with be[0] clears both DAC FIFOs; bit8=1 with be[1] clears overrun; bit9=1 with be[1] clears underrun. Bits 0 and 1 are self-clearing and read back 0.
  - Read: {22'b0, underrun, overrun, 8'b0}.
- Fifospace register (offset 1, read-only):
  - Fields: [31:24] DAC-left free; [23:16] DAC-right free; [15:8] ADC-right count; [7:0] ADC-left count. Each field is 8-bit, value 0..DEPTH.
  - Values are sampled in the IDLE cycle of the access.
  - Writes are acked and ignored.
- Left/right data registers (offsets 2, 3):
  - Write pushes bus_write_data into the DAC FIFO of that channel. If that FIFO is full, the data is dropped and overrun is set.
  - Read pops the ADC FIFO of that channel and returns its head. If that FIFO is empty, the read returns 0, nothing is popped, and underrun is set.
- Codec side:
  - dac_req pops one entry from each DAC FIFO. dac_left/dac_right are registered and dac_valid pulses on the next cycle. An empty channel outputs 0 and sets underrun; the other channel pops normally.
  - adc_val pushes adc_left/adc_right into the ADC FIFOs. A full FIFO drops the sample and sets overrun, independently per channel.
- Simultaneous events:
  - A push and a pop on the same FIFO in one cycle both take effect; count is unchanged. Push into an empty FIFO while popping it counts as empty: the pop returns 0 and sets underrun, and the push succeeds.
  - A clear command beats a same-cycle push or pop on that FIFO.
  - Flag set and clear in the same cycle: set wins.
- Pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits and is zero-extended into its 8-bit field.

Decomposition:
- Package audio_core_pkg:
  - offset constants REG_CTRL=0, REG_FIFOSPACE=1, REG_LEFT=2, REG_RIGHT=3;
  - control bit positions;
  - FSM state enum.
- One sub-module, sync_fifo:
  - parameters DW, DEPTH;
  - show-ahead head output;
  - push, pop, clr inputs;
  - full, empty, count outputs;
  - async active-low reset.
- Instantiated four times.

Test Plan:
- After reset, read 0x3044 → ack on 2nd cycle, data 32'h8080_0000 (DEPTH=128).
- Write 0x11111111 to 0x3048 and 0x22222222 to 0x304c, then pulse dac_req → next cycle dac_valid=1, dac_left=0x11111111, dac_right=0x22222222; fifospace[31:16]=16'h8080.
- Pulse adc_val with left=0xAAAA0001, right=0x5555FFFE; read 0x3044 → [15:0]=16'h0101. Read 0x3048 → 0xAAAA0001; read 0x304c → 0x5555FFFE; fifospace[15:0] then 0.
- Issue 129 left writes → the 129th is dropped; control reads 32'h100. Write 32'h100 with be=4'b0010 → control reads 0.
- Hold bus_read high for 4 cycles on 0x3048 with 2 entries queued → exactly one pop; count is 1 afterwards.
- Fill the ADC FIFOs with 3 entries, assert rst=0 mid-transaction for 1 cycle → bus_ack=0 immediately; fifospace reads 32'h8080_0000 after release.

Source files
------------

// File: rtl/audio_core_pkg.sv
// Shared constants for the audio core register window.
//   - Register offsets (word index within the 16-byte window)
//   - Control register bit positions
//   - Bus handshake FSM state encodings
package audio_core_pkg;

    // Word offsets, taken from bus_addr[3:2]
    localparam logic [1:0] REG_CTRL      = 2'd0;
    localparam logic [1:0] REG_FIFOSPACE = 2'd1;
    localparam logic [1:0] REG_LEFT      = 2'd2;
    localparam logic [1:0] REG_RIGHT     = 2'd3;

    // Control register bits
    localparam int unsigned CTRL_CLR_ADC = 0;  // self-clearing, needs be[0]
    localparam int unsigned CTRL_CLR_DAC = 1;  // self-clearing, needs be[0]
    localparam int unsigned CTRL_CLR_OVR = 8;  // needs be[1]
    localparam int unsigned CTRL_CLR_UNR = 9;  // needs be[1]

    // Bus handshake FSM
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ACK     = 2'd1;
    localparam state_t ST_RELEASE = 2'd2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head output.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   push, push_data   write request and data (dropped when full unless popped same cycle)
//   pop               read request (ignored when empty)
//   clr               synchronous flush; beats a same-cycle push or pop
//   head              entry at the read pointer (valid only when !empty)
//   full, empty       status
//   count             number of stored entries, 0..DEPTH
module sync_fifo #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic                     pop,
    input  logic                     clr,
    output logic [DW-1:0]            head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));
    assign count = cnt_q;
    assign head  = mem[rd_ptr_q];

    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage has no reset; contents are only observed while !empty.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/audio_fifo_responder.sv
// Avalon-MM slave for the four-register audio core window.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   bus_addr/read/write/...       Avalon-MM slave side; bus_ack pulses one cycle per access
//   bus_read_data                 registered read data, valid while bus_ack=1
//   dac_req -> dac_left/right     codec serializer side; dac_valid pulses one cycle after dac_req
//   adc_val, adc_left/right       codec deserializer side; one stereo sample per pulse
module audio_fifo_responder
    import audio_core_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3040,
    parameter int unsigned DEPTH     = 128,
    parameter int unsigned DW        = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   bus_addr,
    input  logic          bus_read,
    input  logic          bus_write,
    input  logic [3:0]    bus_byte_enable,
    input  logic [31:0]   bus_write_data,
    output logic [31:0]   bus_read_data,
    output logic          bus_ack,
    input  logic          dac_req,
    output logic [DW-1:0] dac_left,
    output logic [DW-1:0] dac_right,
    output logic          dac_valid,
    input  logic          adc_val,
    input  logic [DW-1:0] adc_left,
    input  logic [DW-1:0] adc_right
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    state_t        state_q, state_d;
    logic          ack_q;
    logic [31:0]   rdata_q, rdata_d;
    logic          ovr_q, unr_q;
    logic [DW-1:0] dac_left_q, dac_right_q;
    logic          dac_valid_q;

    logic          hit, access, is_rd, is_wr, ctrl_wr;
    logic [1:0]    offset;
    logic          clr_adc, clr_dac, clr_ovr, clr_unr;
    logic          set_ovr, set_unr;

    logic          dacl_push, dacr_push, adcl_pop, adcr_pop;
    logic [DW-1:0] dacl_head, dacr_head, adcl_head, adcr_head;
    logic          dacl_full, dacr_full, adcl_full, adcr_full;
    logic          dacl_empty, dacr_empty, adcl_empty, adcr_empty;
    logic [CW-1:0] dacl_cnt, dacr_cnt, adcl_cnt, adcr_cnt;

    logic          unused_bits;
    assign unused_bits = ^{bus_addr[1:0], bus_byte_enable[3:2]};

    // ---------------- Bus decode ----------------
    assign hit     = (bus_addr[31:4] == BASE_ADDR[31:4]);
    assign offset  = bus_addr[3:2];
    assign access  = (state_q == ST_IDLE) && hit && (bus_read || bus_write);
    assign is_rd   = access && bus_read;
    assign is_wr   = access && bus_write && !bus_read;  // read wins
    assign ctrl_wr = is_wr && (offset == REG_CTRL);

    assign clr_adc = ctrl_wr && bus_byte_enable[0] && bus_write_data[CTRL_CLR_ADC];
    assign clr_dac = ctrl_wr && bus_byte_enable[0] && bus_write_data[CTRL_CLR_DAC];
    assign clr_ovr = ctrl_wr && bus_byte_enable[1] && bus_write_data[CTRL_CLR_OVR];
    assign clr_unr = ctrl_wr && bus_byte_enable[1] && bus_write_data[CTRL_CLR_UNR];

    assign dacl_push = is_wr && (offset == REG_LEFT);
    assign dacr_push = is_wr && (offset == REG_RIGHT);
    assign adcl_pop  = is_rd && (offset == REG_LEFT);
    assign adcr_pop  = is_rd && (offset == REG_RIGHT);

    // ---------------- FIFOs ----------------
    sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_dac_left (
        .clk(clk), .rst(rst), .push(dacl_push), .push_data(bus_write_data[DW-1:0]),
        .pop(dac_req), .clr(clr_dac), .head(dacl_head), .full(dacl_full),
        .empty(dacl_empty), .count(dacl_cnt)
    );

    sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_dac_right (
        .clk(clk), .rst(rst), .push(dacr_push), .push_data(bus_write_data[DW-1:0]),
        .pop(dac_req), .clr(clr_dac), .head(dacr_head), .full(dacr_full),
        .empty(dacr_empty), .count(dacr_cnt)
    );

    sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_adc_left (
        .clk(clk), .rst(rst), .push(adc_val), .push_data(adc_left),
        .pop(adcl_pop), .clr(clr_adc), .head(adcl_head), .full(adcl_full),
        .empty(adcl_empty), .count(adcl_cnt)
    );

    sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_adc_right (
        .clk(clk), .rst(rst), .push(adc_val), .push_data(adc_right),
        .pop(adcr_pop), .clr(clr_adc), .head(adcr_head), .full(adcr_full),
        .empty(adcr_empty), .count(adcr_cnt)
    );

    // ---------------- Sticky flags ----------------
    // A push into a full FIFO is dropped unless that FIFO pops in the same cycle.
    // Pushes discarded by a clear are not overruns.
    assign set_ovr = (dacl_push && dacl_full && !(dac_req && !dacl_empty) && !clr_dac)
                  || (dacr_push && dacr_full && !(dac_req && !dacr_empty) && !clr_dac)
                  || (adc_val && adcl_full && !(adcl_pop && !adcl_empty) && !clr_adc)
                  || (adc_val && adcr_full && !(adcr_pop && !adcr_empty) && !clr_adc);

    assign set_unr = (adcl_pop && adcl_empty)
                  || (adcr_pop && adcr_empty)
                  || (dac_req && (dacl_empty || dacr_empty));

    // ---------------- Read mux ----------------
    always_comb begin
        rdata_d = '0;
        case (offset)
            REG_CTRL:      rdata_d = {22'b0, unr_q, ovr_q, 8'b0};
            REG_FIFOSPACE: rdata_d = {8'(CW'(DEPTH) - dacl_cnt), 8'(CW'(DEPTH) - dacr_cnt),
                                      8'(adcr_cnt), 8'(adcl_cnt)};
            REG_LEFT:      rdata_d = adcl_empty ? 32'b0 : 32'(adcl_head);
            REG_RIGHT:     rdata_d = adcr_empty ? 32'b0 : 32'(adcr_head);
            default:       rdata_d = '0;
        endcase
    end

    // ---------------- Handshake FSM ----------------
    // RELEASE holds off a second access until the master drops its request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (access) state_d = ST_ACK;
            ST_ACK:     state_d = ST_RELEASE;
            ST_RELEASE: if (!bus_read && !bus_write) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            ovr_q       <= 1'b0;
            unr_q       <= 1'b0;
            dac_left_q  <= '0;
            dac_right_q <= '0;
            dac_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= access;
            if (access) rdata_q <= is_rd ? rdata_d : 32'b0;

            // Set beats clear.
            if (set_ovr)      ovr_q <= 1'b1;
            else if (clr_ovr) ovr_q <= 1'b0;
            if (set_unr)      unr_q <= 1'b1;
            else if (clr_unr) unr_q <= 1'b0;

            dac_valid_q <= dac_req;
            if (dac_req) begin
                dac_left_q  <= (dacl_empty || clr_dac) ? '0 : dacl_head;
                dac_right_q <= (dacr_empty || clr_dac) ? '0 : dacr_head;
            end
        end
    end

    assign bus_ack       = ack_q;
    assign bus_read_data = rdata_q;
    assign dac_left      = dac_left_q;
    assign dac_right     = dac_right_q;
    assign dac_valid     = dac_valid_q;

endmodule

// File: tb/tb_audio_fifo_responder.sv
module tb_audio_fifo_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bus_addr;
    logic        bus_read;
    logic        bus_write;
    logic [3:0]  bus_byte_enable;
    logic [31:0] bus_write_data;
    logic [31:0] bus_read_data;
    logic        bus_ack;
    logic        dac_req;
    logic [31:0] dac_left;
    logic [31:0] dac_right;
    logic        dac_valid;
    logic        adc_val;
    logic [31:0] adc_left;
    logic [31:0] adc_right;

    localparam logic [31:0] A_CTRL  = 32'h3040;
    localparam logic [31:0] A_SPACE = 32'h3044;
    localparam logic [31:0] A_LEFT  = 32'h3048;
    localparam logic [31:0] A_RIGHT = 32'h304c;

    audio_fifo_responder dut (
        .clk(clk), .rst(rst),
        .bus_addr(bus_addr), .bus_read(bus_read), .bus_write(bus_write),
        .bus_byte_enable(bus_byte_enable), .bus_write_data(bus_write_data),
        .bus_read_data(bus_read_data), .bus_ack(bus_ack),
        .dac_req(dac_req), .dac_left(dac_left), .dac_right(dac_right), .dac_valid(dac_valid),
        .adc_val(adc_val), .adc_left(adc_left), .adc_right(adc_right)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] val;
    } exp_t;

    exp_t bus_q[$];
    exp_t dac_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compares whenever the DUT presents read data or a DAC sample.
    always @(negedge clk) begin
        exp_t e;
        if (rst && bus_ack && bus_read) begin
            if (bus_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_read_ack: got data %h, expected no ack", bus_read_data);
            end else begin
                e = bus_q.pop_front();
                check(e.name, {32'b0, bus_read_data}, e.val);
            end
        end
        if (rst && dac_valid) begin
            if (dac_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_dac_valid: got %h/%h, expected none",
                         dac_left, dac_right);
            end else begin
                e = dac_q.pop_front();
                check(e.name, {dac_left, dac_right}, e.val);
            end
        end
    end

    task automatic bus_xfer(input logic rd, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] be, input int hold);
        int cyc;
        @(negedge clk);
        bus_addr        = addr;
        bus_write_data  = data;
        bus_byte_enable = be;
        bus_read        = rd;
        bus_write       = !rd;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!bus_ack && cyc < 8);
        check("ack_latency", 64'(cyc), 64'd1);
        repeat (hold) @(posedge clk);
        @(posedge clk);
        #1;
        bus_read  = 1'b0;
        bus_write = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name,
                      input int hold = 0);
        exp_t e;
        e.name = name;
        e.val  = {32'b0, exp};
        bus_q.push_back(e);
        bus_xfer(1'b1, addr, 32'b0, 4'hf, hold);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] be = 4'hf);
        bus_xfer(1'b0, addr, data, be, 0);
    endtask

    task automatic dac_pulse(input logic [31:0] l, input logic [31:0] r, input string name);
        exp_t e;
        e.name = name;
        e.val  = {l, r};
        dac_q.push_back(e);
        @(negedge clk);
        dac_req = 1'b1;
        @(posedge clk);
        #1;
        check("dac_valid_latency", {63'b0, dac_valid}, 64'd1);
        @(negedge clk);
        dac_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic adc_pulse(input logic [31:0] l, input logic [31:0] r);
        @(negedge clk);
        adc_val   = 1'b1;
        adc_left  = l;
        adc_right = r;
        @(negedge clk);
        adc_val = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        bus_addr = '0; bus_read = 0; bus_write = 0; bus_byte_enable = '0; bus_write_data = '0;
        dac_req = 0; adc_val = 0; adc_left = '0; adc_right = '0;
        repeat (3) @(negedge clk);
        check("rst_ack",       {63'b0, bus_ack}, 64'd0);
        check("rst_rdata",     {32'b0, bus_read_data}, 64'd0);
        check("rst_dac_data",  {dac_left, dac_right}, 64'd0);
        check("rst_dac_valid", {63'b0, dac_valid}, 64'd0);
        rst = 1'b1;

        rd(A_SPACE, 32'h8080_0000, "fifospace_after_reset");

        // DAC path
        wr(A_LEFT,  32'h1111_1111);
        wr(A_RIGHT, 32'h2222_2222);
        rd(A_SPACE, 32'h7f7f_0000, "fifospace_dac_one");
        dac_pulse(32'h1111_1111, 32'h2222_2222, "dac_sample");
        rd(A_SPACE, 32'h8080_0000, "fifospace_dac_drained");
        dac_pulse(32'h0, 32'h0, "dac_empty_sample");
        rd(A_CTRL, 32'h200, "ctrl_dac_underrun");
        wr(A_CTRL, 32'h200, 4'b0001);
        rd(A_CTRL, 32'h200, "ctrl_clear_needs_be1");
        wr(A_CTRL, 32'h200, 4'b0010);
        rd(A_CTRL, 32'h0, "ctrl_underrun_cleared");

        // ADC path
        adc_pulse(32'hAAAA_0001, 32'h5555_FFFE);
        rd(A_SPACE, 32'h8080_0101, "fifospace_adc_one");
        rd(A_LEFT,  32'hAAAA_0001, "adc_left_data");
        rd(A_RIGHT, 32'h5555_FFFE, "adc_right_data");
        rd(A_SPACE, 32'h8080_0000, "fifospace_adc_drained");
        rd(A_LEFT,  32'h0, "adc_left_empty_read");
        rd(A_CTRL,  32'h200, "ctrl_adc_underrun");
        wr(A_CTRL,  32'h200, 4'b0010);
        rd(A_CTRL,  32'h0, "ctrl_underrun_cleared2");

        // Overrun on DAC left
        for (int i = 0; i < 129; i++) wr(A_LEFT, 32'(i));
        rd(A_SPACE, 32'h0080_0000, "fifospace_dac_left_full");
        rd(A_CTRL,  32'h100, "ctrl_overrun");
        wr(A_CTRL,  32'h100, 4'b0010);
        rd(A_CTRL,  32'h0, "ctrl_overrun_cleared");
        wr(A_CTRL,  32'h2, 4'b0001);
        rd(A_SPACE, 32'h8080_0000, "fifospace_dac_cleared");
        rd(A_CTRL,  32'h0, "ctrl_clear_bits_selfclear");

        // Held read pops exactly once
        adc_pulse(32'h1, 32'h10);
        adc_pulse(32'h2, 32'h20);
        rd(A_LEFT,  32'h1, "adc_left_held_read", 3);
        rd(A_SPACE, 32'h8080_0201, "fifospace_after_held_read");
        rd(A_LEFT,  32'h2, "adc_left_second");
        wr(A_CTRL,  32'h1, 4'b0001);
        rd(A_SPACE, 32'h8080_0000, "fifospace_adc_cleared");

        // Reset in the middle of a transaction
        adc_pulse(32'h3, 32'h30);
        adc_pulse(32'h4, 32'h40);
        adc_pulse(32'h5, 32'h50);
        rd(A_SPACE, 32'h8080_0303, "fifospace_adc_three");
        @(negedge clk);
        bus_addr = A_SPACE;
        bus_read = 1'b1;
        @(posedge clk);
        #1;
        check("ack_before_reset", {63'b0, bus_ack}, 64'd1);
        rst      = 1'b0;
        bus_read = 1'b0;
        #1;
        check("ack_async_reset",   {63'b0, bus_ack}, 64'd0);
        check("rdata_async_reset", {32'b0, bus_read_data}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rd(A_SPACE, 32'h8080_0000, "fifospace_after_reset2");
        rd(A_CTRL,  32'h0, "ctrl_after_reset2");

        repeat (3) @(negedge clk);
        check("bus_queue_drained", 64'(bus_q.size()), 64'd0);
        check("dac_queue_drained", 64'(dac_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
